shift_sequencer: RTL and testbench

Command-driven controller that sequences an external W-bit universal shift register (parallel load, one-bit left/right shift per clock, no hold mode) to perform multi-bit shift and rotate operations. It accepts one command at a time over a valid/ready handshake. It loads the operand, issues the required number of single-bit shifts with the correct serial fill bit, and captures the final register value into its own result register. It sits between the ALU issue logic and the shared shift register.

---
 rtl/shift_sequencer.sv | 150 +++++++++++++++
 tb/tb_shift_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: drives an external universal shift register through load/shift/capture
// to perform multi-bit LSL/LSR/ASR/ROL/ROR. Latency n+3 cycles; one command in flight.
module shift_sequencer #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_amt,
  input  logic [W-1:0]  cmd_data,
  output logic          sr_load_sel,
  output logic          sr_dir_sel,
  output logic          sr_s_in_l,
  output logic          sr_s_in_r,
  output logic [W-1:0]  sr_p_in,
  input  logic [W-1:0]  sr_q,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  res_data,
  output logic          res_err,
  output logic          busy
);

  localparam int CW = $clog2(W) + 1;

  localparam logic [2:0] OP_LSL = 3'd0;
  localparam logic [2:0] OP_LSR = 3'd1;
  localparam logic [2:0] OP_ASR = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SHIFT   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     op_q, op_d;
  logic [W-1:0]   data_q, data_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;
  logic [W-1:0]   res_data_q, res_data_d;

  logic [31:0]    amt_ext;
  logic [CW-1:0]  sat_amt;
  logic [CW-1:0]  rot_amt;

  // Plain shifts saturate at W (n=W still fully clears or sign-fills); rotates wrap mod W.
  always_comb begin
    amt_ext = 32'(cmd_amt);
    sat_amt = (amt_ext >= 32'(W)) ? CW'(W) : CW'(amt_ext);
    rot_amt = CW'(amt_ext & 32'(W - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= 3'd0;
      data_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      res_data_q <= res_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    res_data_d = res_data_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          data_d  = cmd_data;
          err_d   = 1'b0;
          state_d = S_LOAD;
          case (cmd_op)
            OP_LSL, OP_LSR, OP_ASR: cnt_d = sat_amt;
            OP_ROL, OP_ROR:         cnt_d = rot_amt;
            default: begin
              cnt_d = '0;
              err_d = 1'b1;
            end
          endcase
        end
      end
      S_LOAD:  state_d = (cnt_q != '0) ? S_SHIFT : S_CAPTURE;
      S_SHIFT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        res_data_d = sr_q;
        state_d    = S_DONE;
      end
      S_DONE:  if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = (state_q == S_IDLE);
    busy        = (state_q != S_IDLE);
    res_valid   = (state_q == S_DONE);
    sr_load_sel = 1'b0;
    sr_dir_sel  = 1'b0;
    sr_s_in_l   = 1'b0;
    sr_s_in_r   = 1'b0;
    case (state_q)
      S_LOAD:  sr_load_sel = 1'b1;
      S_SHIFT: begin
        case (op_q)
          OP_LSR: sr_dir_sel = 1'b1;
          OP_ASR: begin
            sr_dir_sel = 1'b1;
            sr_s_in_l  = sr_q[W-1];
          end
          OP_ROL: sr_s_in_r = sr_q[W-1];
          OP_ROR: begin
            sr_dir_sel = 1'b1;
            sr_s_in_l  = sr_q[0];
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign sr_p_in  = data_q;
  assign res_data = res_data_q;
  assign res_err  = err_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: models the external shift register, runs a vector table
// through a result scoreboard, then backpressure and mid-shift reset sequences.
module tb_shift_sequencer;

  localparam int W  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_amt;
  logic [W-1:0]  cmd_data;
  logic          sr_load_sel, sr_dir_sel, sr_s_in_l, sr_s_in_r;
  logic [W-1:0]  sr_p_in;
  logic [W-1:0]  sr_q;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_data;
  logic          res_err;
  logic          busy;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.W(W), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_amt(cmd_amt), .cmd_data(cmd_data),
    .sr_load_sel(sr_load_sel), .sr_dir_sel(sr_dir_sel),
    .sr_s_in_l(sr_s_in_l), .sr_s_in_r(sr_s_in_r),
    .sr_p_in(sr_p_in), .sr_q(sr_q),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err), .busy(busy)
  );

  // External universal shift register: load, or shift one bit; no hold mode.
  always @(posedge clk) begin
    if (reset)            sr_q <= '0;
    else if (sr_load_sel) sr_q <= sr_p_in;
    else if (sr_dir_sel)  sr_q <= {sr_s_in_l, sr_q[W-1:1]};
    else                  sr_q <= {sr_q[W-2:0], sr_s_in_r};
  end

  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] amt;
    logic [W-1:0]  data;
    logic [W-1:0]  exp_data;
    logic          exp_err;
    int            exp_lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] data;
    logic         err;
    int           lat;
  } exp_t;

  vec_t vecs[16];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one command, push its expectation, return just after the accept edge.
  task automatic send(input logic [2:0] op, input logic [AW-1:0] amt, input logic [W-1:0] data,
                      input logic [W-1:0] ed, input logic ee, input int el);
    exp_t e;
    check("cmd_ready_before_send", {31'd0, cmd_ready}, 32'd1);
    cmd_op = op; cmd_amt = amt; cmd_data = data; cmd_valid = 1'b1;
    e.data = ed; e.err = ee; e.lat = el;
    sb.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Called in cycle 1 after accept; waits (bounded) for res_valid and scores it.
  task automatic collect(input string name);
    exp_t e;
    int cyc = 1;
    while (!res_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_valid"}, {31'd0, res_valid}, 32'd1);
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({name, "_data"}, {24'd0, res_data}, {24'd0, e.data});
      check({name, "_err"}, {31'd0, res_err}, {31'd0, e.err});
      check({name, "_lat"}, cyc, e.lat);
    end
  endtask

  task automatic ack(input string name);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({name, "_ack_valid"}, {31'd0, res_valid}, 32'd0);
    check({name, "_ack_ready"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{3'd0, 4'd3,  8'hB5, 8'hA8, 1'b0, 6};
    vecs[1]  = '{3'd2, 4'd2,  8'h90, 8'hE4, 1'b0, 5};
    vecs[2]  = '{3'd3, 4'd1,  8'h81, 8'h03, 1'b0, 4};
    vecs[3]  = '{3'd4, 4'd9,  8'h81, 8'hC0, 1'b0, 4};
    vecs[4]  = '{3'd1, 4'd15, 8'hFF, 8'h00, 1'b0, 11};
    vecs[5]  = '{3'd0, 4'd0,  8'h3C, 8'h3C, 1'b0, 3};
    vecs[6]  = '{3'd4, 4'd0,  8'hA7, 8'hA7, 1'b0, 3};
    vecs[7]  = '{3'd3, 4'd8,  8'hA7, 8'hA7, 1'b0, 3};
    vecs[8]  = '{3'd6, 4'd7,  8'h5A, 8'h5A, 1'b1, 3};
    vecs[9]  = '{3'd2, 4'd12, 8'h80, 8'hFF, 1'b0, 11};
    vecs[10] = '{3'd0, 4'd8,  8'hFF, 8'h00, 1'b0, 11};
    vecs[11] = '{3'd4, 4'd3,  8'h96, 8'hD2, 1'b0, 6};
    vecs[12] = '{3'd1, 4'd4,  8'h96, 8'h09, 1'b0, 7};
    vecs[13] = '{3'd3, 4'd13, 8'h96, 8'hD2, 1'b0, 8};
    vecs[14] = '{3'd7, 4'd0,  8'hC3, 8'hC3, 1'b1, 3};
    vecs[15] = '{3'd2, 4'd3,  8'h40, 8'h08, 1'b0, 6};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_amt = '0; cmd_data = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_data", {24'd0, res_data}, 32'd0);
    check("rst_res_err", {31'd0, res_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sr_ctl", {28'd0, sr_load_sel, sr_dir_sel, sr_s_in_l, sr_s_in_r}, 32'd0);
    check("rst_sr_p_in", {24'd0, sr_p_in}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      send(vecs[i].op, vecs[i].amt, vecs[i].data, vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_lat);
      collect($sformatf("vec%0d", i));
      ack($sformatf("vec%0d", i));
    end

    // Backpressure: result held, second command ignored until after the handshake.
    send(3'd0, 4'd1, 8'h01, 8'h02, 1'b0, 4);
    collect("bp_first");
    cmd_op = 3'd0; cmd_amt = 4'd1; cmd_data = 8'hFF; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold_valid%0d", i), {31'd0, res_valid}, 32'd1);
      check($sformatf("bp_hold_data%0d", i), {24'd0, res_data}, 32'h02);
      check($sformatf("bp_hold_ready%0d", i), {31'd0, cmd_ready}, 32'd0);
    end
    ack("bp_first");
    check("bp_busy_idle", {31'd0, busy}, 32'd0);
    sb.push_back('{8'hFE, 1'b0, 4});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    collect("bp_second");
    ack("bp_second");

    // Reset in cycle 3 of an 8-step shift aborts the operation.
    send(3'd1, 4'd8, 8'hFF, 8'h00, 1'b0, 11);
    check("mid_load_sel", {31'd0, sr_load_sel}, 32'd1);
    check("mid_p_in", {24'd0, sr_p_in}, 32'hFF);
    @(posedge clk); #1;
    check("mid_shift_ctl", {30'd0, sr_load_sel, sr_dir_sel}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    void'(sb.pop_front());
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("abort_res_valid", {31'd0, res_valid}, 32'd0);
    check("abort_res_data", {24'd0, res_data}, 32'd0);
    check("abort_load_sel", {31'd0, sr_load_sel}, 32'd0);
    send(3'd3, 4'd1, 8'h81, 8'h03, 1'b0, 4);
    collect("post_abort");
    ack("post_abort");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
